// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for booth_mult_seq.
//   in_valid/in_ready  : operand issue handshake (a, b, is_signed)
//   out_valid/out_ready: product delivery handshake (p)
//   busy               : multiplier is calculating or holding a result
// slave modport is the multiplier side, master the issuing/consuming side.
interface booth_mult_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, p, busy
  );

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one Booth digit per clock.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : booth_mult_seq_if.slave (operands in, product out, busy)
// Operands are extended to WIDTH+2 bits so that the same digit recoding
// yields the exact product for both signed and unsigned inputs. All outputs
// come from flops (p) or are decoded from the state register.
module booth_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_mult_seq_if.slave  bus
);
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;        // extended operand width
  localparam int AW   = 2 * WIDTH + 4;    // accumulator width
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [AW-1:0]      mc_q, mc_d;         // multiplicand, pre-shifted by 2i
  logic [EW-1:0]      mb_q, mb_d;         // multiplier, shifted right 2/cycle
  logic               prev_q, prev_d;     // b[2i-1] of the current digit
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [EW-1:0]      a_ext, b_ext;
  logic [2:0]         trip;
  logic [AW-1:0]      mult;

  always_comb begin
    a_ext = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    b_ext = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
  end

  // Booth digit select on the current low triplet of the shifted multiplier.
  always_comb begin
    trip = {mb_q[1], mb_q[0], prev_q};
    mult = '0;
    case (trip)
      3'b001, 3'b010: mult = mc_q;
      3'b011:         mult = mc_q << 1;
      3'b100:         mult = -(mc_q << 1);
      3'b101, 3'b110: mult = -mc_q;
      default:        mult = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mb_d    = mb_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // the multiplicand is carried at accumulator width so negated
          // multiples stay correct after the left shifts
          mc_d    = {{(AW-EW){a_ext[EW-1]}}, a_ext};
          mb_d    = b_ext;
          prev_d  = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == CW'(NDIG)) begin
          p_d     = acc_q[2*WIDTH-1:0];
          state_d = DONE;
        end else begin
          acc_d  = acc_q + mult;
          mc_d   = mc_q << 2;
          mb_d   = mb_q >> 2;
          prev_d = mb_q[1];
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mc_q    <= '0;
      mb_q    <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mb_q    <= mb_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.p         = p_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: WIDTH=16 and WIDTH=8 instances.
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(16)) b16 ();
  booth_mult_seq_if #(.WIDTH(8))  b8 ();

  booth_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  booth_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one WIDTH=16 op; garbage is driven on the inputs during CALC.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] exp, input string tag, input bit full);
    int n;
    b16.a = a; b16.b = b; b16.is_signed = s; b16.in_valid = 1'b1;
    tick;
    n = 0;
    while (!b16.out_valid && n < 40) begin
      b16.in_valid  = 1'($urandom_range(0, 1));
      b16.a         = 16'($urandom);
      b16.b         = 16'($urandom);
      b16.is_signed = 1'($urandom_range(0, 1));
      tick;
      n++;
    end
    b16.in_valid = 1'b0;
    chk({tag, " p"}, 64'(b16.p), 64'(exp));
    if (full) begin
      chk({tag, " latency"}, 64'(n), 64'd10);
      chk({tag, " busy"}, 64'(b16.busy), 64'd1);
    end
    b16.out_ready = 1'b1;
    tick;
    b16.out_ready = 1'b0;
    if (full) begin
      chk({tag, " in_ready after"}, 64'(b16.in_ready), 64'd1);
      chk({tag, " out_valid after"}, 64'(b16.out_valid), 64'd0);
      chk({tag, " p held"}, 64'(b16.p), 64'(exp));
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp, input string tag);
    int n;
    b8.a = a; b8.b = b; b8.is_signed = s; b8.in_valid = 1'b1;
    tick;
    b8.in_valid = 1'b0;
    n = 0;
    while (!b8.out_valid && n < 40) begin
      tick;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'd6);
    chk({tag, " p"}, 64'(b8.p), 64'(exp));
    b8.out_ready = 1'b1;
    tick;
    b8.out_ready = 1'b0;
    chk({tag, " in_ready after"}, 64'(b8.in_ready), 64'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rs;
    longint      xa, xb, prod;
    int          seen;

    b16.in_valid = 0; b16.a = 0; b16.b = 0; b16.is_signed = 0; b16.out_ready = 0;
    b8.in_valid  = 0; b8.a  = 0; b8.b  = 0; b8.is_signed  = 0; b8.out_ready  = 0;
    rst_n = 1'b0;
    #1;
    chk("reset in_ready", 64'(b16.in_ready), 64'd1);
    chk("reset out_valid", 64'(b16.out_valid), 64'd0);
    chk("reset busy", 64'(b16.busy), 64'd0);
    chk("reset p", 64'(b16.p), 64'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u max", 1'b1);
    run16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s min*min", 1'b1);
    run16(16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF, "s -1*1", 1'b1);
    run16(16'h0000, 16'h8000, 1'b1, 32'h00000000, "s 0*min", 1'b1);
    run16(16'h1234, 16'h5678, 1'b0, 32'h06260060, "u mixed", 1'b1);
    run16(16'h1234, 16'h5678, 1'b1, 32'h06260060, "s mixed", 1'b1);

    // backpressure: hold result, new operands must be ignored
    b16.a = 16'h0003; b16.b = 16'h0007; b16.is_signed = 1'b0; b16.in_valid = 1'b1;
    tick;
    b16.in_valid = 1'b0;
    seen = 0;
    while (!b16.out_valid && seen < 40) begin tick; seen++; end
    for (int i = 0; i < 5; i++) begin
      b16.in_valid = 1'b1; b16.a = 16'hAAAA; b16.b = 16'h5555;
      tick;
      chk("bp p", 64'(b16.p), 64'h15);
      chk("bp out_valid", 64'(b16.out_valid), 64'd1);
      chk("bp in_ready", 64'(b16.in_ready), 64'd0);
    end
    b16.in_valid = 1'b0;
    b16.out_ready = 1'b1;
    tick;
    b16.out_ready = 1'b0;
    chk("bp release out_valid", 64'(b16.out_valid), 64'd0);
    chk("bp release in_ready", 64'(b16.in_ready), 64'd1);

    // reset 4 cycles into an operation
    b16.a = 16'hFFFF; b16.b = 16'hFFFF; b16.is_signed = 1'b0; b16.in_valid = 1'b1;
    tick;
    b16.in_valid = 1'b0;
    tick; tick; tick; tick;
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", 64'(b16.in_ready), 64'd1);
    chk("abort out_valid", 64'(b16.out_valid), 64'd0);
    chk("abort busy", 64'(b16.busy), 64'd0);
    chk("abort p", 64'(b16.p), 64'd0);
    tick;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (b16.out_valid) seen++;
    end
    chk("abort no out_valid", 64'(seen), 64'd0);
    run16(16'd3, 16'd5, 1'b0, 32'h0000000F, "after abort", 1'b1);

    run8(8'h80, 8'h7F, 1'b1, 16'hC080, "w8 s");
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8 u");

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      xa = rs ? longint'($signed(ra)) : longint'(ra);
      xb = rs ? longint'($signed(rb)) : longint'(rb);
      prod = xa * xb;
      run16(ra, rb, rs, prod[31:0], "rand", 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
